// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding, the I/O port address and
// the cpu_rw encoding.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold,
        StDone
    } state_t;

    localparam logic [15:0] IO_ADDR  = 16'hFF00;
    localparam logic        RW_READ  = 1'b1;
    localparam logic        RW_WRITE = 1'b0;

endpackage

// File: rtl/sram_ctrl.sv
// Async SRAM controller stalling a divided-clock CPU for each bus access.
// Optional macro SRAM_CTRL_IO_PORT_EN maps an 8-bit output port at IO_ADDR.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_tick,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_doe,
    input  logic [7:0]  sram_din,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        overrun
`ifdef SRAM_CTRL_IO_PORT_EN
    ,
    output logic [7:0]  io_port
`endif
);

    localparam int unsigned EffWait = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CntW    = (EffWait > 1) ? $clog2(EffWait) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(EffWait - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [15:0]     addr_q;
    logic            rw_q;
    logic [7:0]      wdata_q;
    logic [7:0]      rdata_q;
    logic            overrun_q;
    logic            is_io;

`ifdef SRAM_CTRL_IO_PORT_EN
    logic [7:0] io_port_q;
    assign is_io   = (addr_q == IO_ADDR);
    assign io_port = io_port_q;
`else
    assign is_io = 1'b0;
`endif

    // State register plus the datapath registers it sequences
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= 16'h0000;
            rw_q      <= RW_READ;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            overrun_q <= 1'b0;
`ifdef SRAM_CTRL_IO_PORT_EN
            io_port_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && cpu_tick) begin
                addr_q  <= cpu_addr;
                rw_q    <= cpu_rw;
                wdata_q <= cpu_wdata;
            end
            if (state_q != StIdle && cpu_tick) begin
                overrun_q <= 1'b1;
            end
            if (state_q == StSetup) begin
                cnt_q <= CntLoad;
            end else if (state_q == StAccess && cnt_q != '0) begin
                cnt_q <= cnt_q - CntW'(1);
            end
            if (state_q == StAccess && cnt_q == '0 && rw_q == RW_READ) begin
                rdata_q <= sram_din;
            end
`ifdef SRAM_CTRL_IO_PORT_EN
            // I/O accesses complete in SETUP without touching the SRAM
            if (state_q == StSetup && is_io) begin
                if (rw_q == RW_READ) begin
                    rdata_q <= io_port_q;
                end else begin
                    io_port_q <= wdata_q;
                end
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu_tick) state_d = StSetup;
            StSetup:  state_d = is_io ? StDone : StAccess;
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = (rw_q == RW_READ) ? StDone : StHold;
                end
            end
            StHold:   state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_doe  = 1'b0;
        unique case (state_q)
            StSetup: begin
                if (!is_io) begin
                    sram_ce_n = 1'b0;
                    if (rw_q == RW_READ) sram_oe_n = 1'b0;
                    else                 sram_doe  = 1'b1;
                end
            end
            StAccess: begin
                sram_ce_n = 1'b0;
                if (rw_q == RW_READ) begin
                    sram_oe_n = 1'b0;
                end else begin
                    sram_we_n = 1'b0;
                    sram_doe  = 1'b1;
                end
            end
            StHold: begin
                sram_ce_n = 1'b0;
                sram_doe  = (rw_q == RW_WRITE);
            end
            default: ;
        endcase
    end

    assign cpu_stall = (state_q != StIdle);
    assign cpu_rdata = rdata_q;
    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: directed accesses push expected results, a monitor
// measures each completed access on the strobes. Honours SRAM_CTRL_IO_PORT_EN.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_tick;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic [7:0]  sram_din;

    logic [7:0]  rdata0, rdata1, dout0, dout1;
    logic        stall0, stall1, doe0, doe1, ovr0, ovr1;
    logic [15:0] saddr0, saddr1;
    logic        ce0, oe0, we0, ce1, oe1, we1;
`ifdef SRAM_CTRL_IO_PORT_EN
    logic [7:0]  io0, io1;
`endif

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .cpu_tick(cpu_tick), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rdata0), .cpu_stall(stall0), .sram_addr(saddr0),
        .sram_dout(dout0), .sram_doe(doe0), .sram_din(sram_din), .sram_ce_n(ce0),
        .sram_oe_n(oe0), .sram_we_n(we0), .overrun(ovr0)
`ifdef SRAM_CTRL_IO_PORT_EN
        , .io_port(io0)
`endif
    );

    sram_ctrl #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .cpu_tick(cpu_tick), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1), .cpu_stall(stall1), .sram_addr(saddr1),
        .sram_dout(dout1), .sram_doe(doe1), .sram_din(sram_din), .sram_ce_n(ce1),
        .sram_oe_n(oe1), .sram_we_n(we1), .overrun(ovr1)
`ifdef SRAM_CTRL_IO_PORT_EN
        , .io_port(io1)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          n_stall;
        int          n_oe;
        int          n_we;
        int          n_ce;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   both_low = 0;
    int   doe_idle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: measures each dut0 access and scores it when cpu_stall falls
    int  m_stall = 0, m_oe = 0, m_we = 0, m_ce = 0, m_dout_bad = 0, m_addr_bad = 0;
    bit  in_txn = 0;
    always @(negedge clk) begin
        if (!we0 && !oe0) both_low++;
        if (doe0 && !stall0) doe_idle++;
        if (rst) begin
            in_txn = 0;
            m_stall = 0; m_oe = 0; m_we = 0; m_ce = 0; m_dout_bad = 0; m_addr_bad = 0;
        end else if (stall0) begin
            in_txn = 1;
            m_stall++;
            if (!oe0) m_oe++;
            if (!we0) m_we++;
            if (!ce0) m_ce++;
            if (exp_q.size() > 0) begin
                if (!we0 && (!doe0 || dout0 !== exp_q[0].wdata)) m_dout_bad++;
                if (!ce0 && saddr0 !== exp_q[0].addr) m_addr_bad++;
            end
        end else if (in_txn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_txn", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_stall"}, m_stall, e.n_stall);
                check({e.name, "_oe_cycles"}, m_oe, e.n_oe);
                check({e.name, "_we_cycles"}, m_we, e.n_we);
                check({e.name, "_ce_cycles"}, m_ce, e.n_ce);
                check({e.name, "_rdata"}, rdata0, e.rdata);
                check({e.name, "_dout_bad"}, m_dout_bad, 0);
                check({e.name, "_addr_bad"}, m_addr_bad, 0);
                check({e.name, "_doe_after"}, doe0, 1'b0);
            end
            in_txn = 0;
            m_stall = 0; m_oe = 0; m_we = 0; m_ce = 0; m_dout_bad = 0; m_addr_bad = 0;
        end
    end

    task automatic push(input string name, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input int ns, input int noe, input int nwe,
                        input int nce);
        exp_t e;
        e.name = name; e.addr = a; e.wdata = wd; e.rdata = rd;
        e.n_stall = ns; e.n_oe = noe; e.n_we = nwe; e.n_ce = nce;
        exp_q.push_back(e);
    endtask

    // Returns just after the edge that samples the tick
    task automatic tick_op(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        @(posedge clk);
        #1;
        cpu_tick = 1'b1; cpu_addr = a; cpu_rw = rw; cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_tick = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!stall0 && !stall1) done = 1;
        end
        check("idle_timeout", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n1, noe1;
        rst = 1'b1; cpu_tick = 1'b0; cpu_addr = '0; cpu_rw = 1'b1; cpu_wdata = '0;
        sram_din = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ce_n", ce0, 1'b1);
        check("rst_oe_n", oe0, 1'b1);
        check("rst_we_n", we0, 1'b1);
        check("rst_doe", doe0, 1'b0);
        check("rst_stall", stall0, 1'b0);
        check("rst_overrun", ovr0, 1'b0);
        check("rst_rdata", rdata0, 8'h00);
        check("rst_addr", saddr0, 16'h0000);

        sram_din = 8'hA5;
        push("read_1234", 16'h1234, 8'h00, 8'hA5, 4, 3, 0, 3);
        tick_op(16'h1234, 1'b1, 8'h00);
        wait_idle();

        push("write_0200", 16'h0200, 8'h3C, 8'hA5, 5, 0, 2, 4);
        tick_op(16'h0200, 1'b0, 8'h3C);
        wait_idle();

        sram_din = 8'h5A;
        push("read_0200", 16'h0200, 8'h00, 8'h5A, 4, 3, 0, 3);
        tick_op(16'h0200, 1'b1, 8'h00);
        wait_idle();

`ifdef SRAM_CTRL_IO_PORT_EN
        push("io_write", 16'hFF00, 8'h42, 8'h5A, 2, 0, 0, 0);
        tick_op(16'hFF00, 1'b0, 8'h42);
        wait_idle();
        check("io_port", io0, 8'h42);
        sram_din = 8'h99;
        push("io_read", 16'hFF00, 8'h00, 8'h42, 2, 0, 0, 0);
        tick_op(16'hFF00, 1'b1, 8'h00);
        wait_idle();
`else
        sram_din = 8'h77;
        push("read_ff00", 16'hFF00, 8'h00, 8'h77, 4, 3, 0, 3);
        tick_op(16'hFF00, 1'b1, 8'h00);
        wait_idle();
`endif

        // WAIT_CYCLES=0 instance must match WAIT_CYCLES=1 timing
        sram_din = 8'hC3;
        push("read_w2_c3", 16'h0042, 8'h00, 8'hC3, 4, 3, 0, 3);
        tick_op(16'h0042, 1'b1, 8'h00);
        n1 = 0; noe1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall1) break;
            n1++;
            if (!oe1) noe1++;
        end
        check("w0_stall", n1, 3);
        check("w0_oe_cycles", noe1, 2);
        check("w0_rdata", rdata1, 8'hC3);
        wait_idle();

        // Second tick lands in ACCESS: ignored, overrun set
        check("ovr_before", ovr0, 1'b0);
        sram_din = 8'h1E;
        push("read_overrun", 16'h0300, 8'h00, 8'h1E, 4, 3, 0, 3);
        tick_op(16'h0300, 1'b1, 8'h00);
        @(posedge clk);
        #1 cpu_tick = 1'b1; cpu_addr = 16'h0400; cpu_rw = 1'b0; cpu_wdata = 8'hEE;
        @(posedge clk);
        #1 cpu_tick = 1'b0;
        wait_idle();
        check("ovr_set", ovr0, 1'b1);
        repeat (3) @(negedge clk);
        check("ovr_sticky", ovr0, 1'b1);
        check("ovr_no_second_txn", exp_q.size(), 0);

        // Reset during the first ACCESS cycle of a write
        tick_op(16'h0500, 1'b0, 8'h81);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_in_access", we0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ce_n", ce0, 1'b1);
        check("midrst_we_n", we0, 1'b1);
        check("midrst_oe_n", oe0, 1'b1);
        check("midrst_doe", doe0, 1'b0);
        check("midrst_stall", stall0, 1'b0);
        check("midrst_overrun", ovr0, 1'b0);
        check("midrst_rdata", rdata0, 8'h00);

        sram_din = 8'h6B;
        push("read_after_rst", 16'h0600, 8'h00, 8'h6B, 4, 3, 0, 3);
        tick_op(16'h0600, 1'b1, 8'h00);
        wait_idle();

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("we_oe_both_low", both_low, 0);
        check("doe_while_idle", doe_idle, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
